// File: rtl/pausible_rx_port_if.sv
// Handshake bundle for pausible_rx_port: the asynchronous 4-phase input side
// and the synchronous valid/ready output side.
interface pausible_rx_port_if #(
  parameter int DATA_W = 8
);
  logic              in_req;
  logic [DATA_W-1:0] in_data;
  logic              in_ack;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_req, in_data, out_ready,
    input  in_ack, out_valid, out_data
  );

  modport slave (
    input  in_req, in_data, out_ready,
    output in_ack, out_valid, out_data
  );
endinterface

// File: rtl/pausible_rx_port.sv
// Async 4-phase bundled-data receiver for the pausible-clock domain. Words are
// captured by grant-transparent latches and pushed into a FIFO read via valid/ready.
//
// state  | meaning
// S_IDLE | no unacknowledged request; in_ack low
// S_ACK  | rising phase captured and pushed; in_ack high until req_l falls
module pausible_rx_port #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 4,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic               clock,
  input  logic               rstn,
  pausible_rx_port_if.slave  bus,
  output logic               req,
  input  logic               grant,
  output logic [CNT_W-1:0]   fill_level
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_req_l;
  logic [DATA_W-1:0] r_data_l;
  logic              r_full;
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]  r_fill;
  logic [CNT_W-1:0]  w_fill_nxt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_push;
  logic              w_pop;
  logic              w_ack;
  logic              w_empty;

  // Capture latches: the clock is held low while grant=1, so these only move
  // when no edge can sample them.
  always_latch begin
    if (!rstn) begin
      r_req_l <= 1'b0;
    end else if (grant) begin
      r_req_l <= bus.in_req;
    end
  end

  always_latch begin
    if (grant) begin
      r_data_l <= bus.in_data;
    end
  end

  // Rising phase is only requested when there is room; the falling phase is always served.
  assign req = (bus.in_req ^ r_req_l) & (~bus.in_req | ~r_full);

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (r_req_l)  w_state_nxt = S_ACK;
      S_ACK:   if (!r_req_l) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_push = 1'b0;
    w_ack  = 1'b0;
    case (r_state)
      S_IDLE:  w_push = r_req_l;
      S_ACK:   w_ack  = 1'b1;
      default: ;
    endcase
  end

  assign w_empty = (r_fill == '0);
  assign w_pop   = ~w_empty & bus.out_ready;

  always_comb begin
    w_fill_nxt = r_fill;
    case ({w_push, w_pop})
      2'b10:   w_fill_nxt = r_fill + CNT_W'(1);
      2'b01:   w_fill_nxt = r_fill - CNT_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
      r_full   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_fill <= w_fill_nxt;
      r_full <= (w_fill_nxt == CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= r_data_l;
  end

  assign bus.in_ack    = w_ack;
  assign bus.out_valid = ~w_empty;
  assign bus.out_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign fill_level    = r_fill;

endmodule

// File: tb/tb_pausible_rx_port.sv
// Bench for pausible_rx_port: behavioural pausible clock, async sender, and a
// scoreboard monitor comparing FIFO output and occupancy against an accepted-minus-consumed model.
module tb_pausible_rx_port;

  // Delays are integer picoseconds (1000 = 1ns).
  logic       clock = 1'b0;
  logic       rstn  = 1'b0;
  logic       grant = 1'b0;
  logic       w_req;
  logic [2:0] fill_level;

  pausible_rx_port_if #(.DATA_W(8)) ifc ();

  pausible_rx_port #(.DATA_W(8), .DEPTH(4)) dut (
    .clock      (clock),
    .rstn       (rstn),
    .bus        (ifc),
    .req        (w_req),
    .grant      (grant),
    .fill_level (fill_level)
  );

  int         errors = 0;
  int         checks = 0;
  int         rd_mode = 0;   // 0 hold, 1 always ready, 2 random, 3 single pop
  int         req_pulses = 0;
  int         ncyc = 0;
  int         max_fill = 0;
  logic [7:0] exp_q [$];

  int         m_pushes, m_pops, m_fill;
  bit         m_pend, m_prev_ack;
  logic       m_rdy;
  logic [7:0] m_exp;

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Pausible clock: grants a pending request in the low phase and holds the
  // clock low until the request is withdrawn.
  initial begin
    int hold;
    #3000;
    forever begin
      #1000;
      if (w_req) begin
        grant = 1'b1;
        hold = 0;
        while (w_req && hold < 500) begin
          #100;
          hold++;
        end
        if (w_req) begin
          errors++;
          checks++;
          $display("FAIL grant_release: req still %0b after grant", w_req);
        end
        #200 grant = 1'b0;
      end
      #4000 clock = 1'b1;
      #5000 clock = 1'b0;
    end
  end

  always @(posedge clock) ncyc++;
  always @(posedge w_req) req_pulses++;

  // Scoreboard monitor: samples on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clock);
      if (!rstn) begin
        m_pushes = 0; m_pops = 0; m_pend = 1'b0; m_prev_ack = 1'b0;
        ifc.out_ready = 1'b0;
        continue;
      end
      if (m_pend) m_pops++;
      m_pend = 1'b0;
      if (ifc.in_ack && !m_prev_ack) m_pushes++;
      m_prev_ack = ifc.in_ack;
      m_fill = m_pushes - m_pops;
      if (int'(fill_level) > max_fill) max_fill = int'(fill_level);
      chk(int'(fill_level) == m_fill, "fill_level", 32'(fill_level), 32'(m_fill));
      chk(ifc.out_valid === (m_fill > 0), "out_valid", 32'(ifc.out_valid), 32'(m_fill > 0));
      chk(!$isunknown({ifc.in_ack, ifc.out_data}), "no_x", {23'd0, ifc.in_ack, ifc.out_data}, 32'd0);
      if (m_fill == 0) chk(ifc.out_data === 8'h00, "out_data_empty", 32'(ifc.out_data), 32'd0);
      case (rd_mode)
        1:       m_rdy = 1'b1;
        2:       m_rdy = 1'($urandom_range(0, 1));
        3:       m_rdy = ifc.out_valid;
        default: m_rdy = 1'b0;
      endcase
      if (rd_mode == 3 && ifc.out_valid) rd_mode = 0;
      ifc.out_ready = m_rdy;
      if (m_rdy && ifc.out_valid) begin
        m_pend = 1'b1;
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_word", 32'(ifc.out_data), 32'd0);
        end else begin
          m_exp = exp_q.pop_front();
          chk(ifc.out_data === m_exp, "out_data", 32'(ifc.out_data), 32'(m_exp));
        end
      end
    end
  end

  task automatic wait_ack(input logic v, input string nm);
    int t = 0;
    while (ifc.in_ack !== v && t < 20000) begin
      #100;
      t++;
    end
    chk(ifc.in_ack === v, nm, 32'(ifc.in_ack), 32'(v));
  endtask

  task automatic raise(input logic [7:0] d);
    ifc.in_data = d;
    exp_q.push_back(d);
    ifc.in_req = 1'b1;
  endtask

  task automatic xfer(input logic [7:0] d, input int off);
    @(posedge clock); #(off);
    raise(d);
    wait_ack(1'b1, "ack_rise");
    @(posedge clock); #(off);
    ifc.in_req = 1'b0;
    wait_ack(1'b0, "ack_fall");
  endtask

  task automatic wait_empty(input string nm);
    int t = 0;
    while ((exp_q.size() != 0 || fill_level != 3'd0) && t < 40000) begin
      #100;
      t++;
    end
    chk(exp_q.size() == 0 && fill_level == 3'd0, nm, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic summary;
    $display("Result: errors=%0d of %0d checks", errors, checks);
  endtask

  initial begin
    #500_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    summary();
    $fatal(1, "timeout");
  end

  initial begin
    int c0;
    bit blocked_req, blocked_ack;
    ifc.in_req = 1'b0;
    ifc.in_data = 8'h00;
    ifc.out_ready = 1'b0;

    // Reset
    #3000;
    chk(w_req === 1'b0, "rst_req", 32'(w_req), 32'd0);
    chk(ifc.in_ack === 1'b0, "rst_in_ack", 32'(ifc.in_ack), 32'd0);
    chk(ifc.out_valid === 1'b0, "rst_out_valid", 32'(ifc.out_valid), 32'd0);
    chk(fill_level === 3'd0, "rst_fill", 32'(fill_level), 32'd0);
    #2000 rstn = 1'b1;
    c0 = ncyc;
    #50000;
    chk(ncyc - c0 >= 4, "clock_running", 32'(ncyc - c0), 32'd4);

    // Single word
    req_pulses = 0;
    @(posedge clock); #2000;
    raise(8'hA5);
    wait_ack(1'b1, "single_ack_rise");
    chk(req_pulses == 1, "single_req_pulses_rise", 32'(req_pulses), 32'd1);
    #500;
    chk(ifc.out_valid === 1'b1, "single_out_valid", 32'(ifc.out_valid), 32'd1);
    chk(ifc.out_data === 8'hA5, "single_out_data", 32'(ifc.out_data), 32'hA5);
    chk(fill_level === 3'd1, "single_fill", 32'(fill_level), 32'd1);
    ifc.in_req = 1'b0;
    wait_ack(1'b0, "single_ack_fall");
    chk(req_pulses == 2, "single_req_pulses_fall", 32'(req_pulses), 32'd2);
    rd_mode = 1;
    wait_empty("single_drain");

    // Fill to full, then a blocked fifth word
    rd_mode = 0;
    #20000;
    for (int i = 1; i <= 4; i++) xfer(8'(i), 3000);
    chk(fill_level === 3'd4, "fill_full", 32'(fill_level), 32'd4);
    @(posedge clock); #2000;
    raise(8'h05);
    blocked_req = 1'b0;
    blocked_ack = 1'b0;
    for (int t = 0; t < 2000; t++) begin
      #100;
      if (w_req !== 1'b0) blocked_req = 1'b1;
      if (ifc.in_ack !== 1'b0) blocked_ack = 1'b1;
    end
    chk(!blocked_req, "full_req_held", 32'(blocked_req), 32'd0);
    chk(!blocked_ack, "full_ack_held", 32'(blocked_ack), 32'd0);
    rd_mode = 3;
    wait_ack(1'b1, "full_ack_after_pop");
    chk(fill_level === 3'd4, "full_refill", 32'(fill_level), 32'd4);
    ifc.in_req = 1'b0;
    wait_ack(1'b0, "full_ack_fall");
    rd_mode = 1;
    wait_empty("full_drain");

    // Streaming with the consumer always ready
    max_fill = 0;
    for (int i = 0; i < 64; i++) xfer(8'(i), 1000 + 100 * (i % 40));
    wait_empty("stream_drain");
    chk(max_fill <= 2, "stream_max_fill", 32'(max_fill), 32'd2);

    // Reset in the middle of a handshake
    rd_mode = 0;
    #20000;
    xfer(8'h11, 2000);
    xfer(8'h22, 2000);
    @(posedge clock); #2000;
    raise(8'h33);
    wait_ack(1'b1, "midrst_ack_rise");
    chk(fill_level === 3'd3, "midrst_fill_before", 32'(fill_level), 32'd3);
    @(posedge clock); #2000;
    rstn = 1'b0;
    ifc.in_req = 1'b0;
    #500;
    chk(ifc.in_ack === 1'b0, "midrst_in_ack", 32'(ifc.in_ack), 32'd0);
    chk(fill_level === 3'd0, "midrst_fill", 32'(fill_level), 32'd0);
    chk(w_req === 1'b0, "midrst_req", 32'(w_req), 32'd0);
    exp_q.delete();
    #12000;
    @(posedge clock); #2000;
    rstn = 1'b1;
    rd_mode = 1;
    xfer(8'h3C, 2500);
    wait_empty("midrst_clean_xfer");

    // Phase sweep of in_req edges across the clock period, random consumer
    rd_mode = 2;
    for (int i = 0; i < 200; i++) xfer(8'($urandom), 100 * (i % 100));
    rd_mode = 1;
    wait_empty("sweep_drain");

    summary();
    $finish;
  end

endmodule
